// File: rtl/mult_seq_ctrl.sv
// Control FSM for the sequential partial-product multiplier: issues NCHUNK x NCHUNK chunk products in diagonal order.
// Build option MULT_SEQ_ABORT_EN: start while busy restarts the operation instead of trapping in ERR.
module mult_seq_ctrl #(
    parameter int NCHUNK = 2,
    parameter int IDX_W  = $clog2(NCHUNK),
    parameter int SH_W   = $clog2(2*NCHUNK-1),
    parameter int ST_W   = $clog2(NCHUNK*NCHUNK)
) (
    input  logic             clk,
    input  logic             reset_a_n,
    input  logic             start,
    output logic [IDX_W-1:0] a_sel,
    output logic [IDX_W-1:0] b_sel,
    output logic [SH_W-1:0]  shift_sel,
    output logic [ST_W-1:0]  step_idx,
    output logic             last_pp,
    output logic             clk_ena,
    output logic             sclr_n,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state_out
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

`ifdef MULT_SEQ_ABORT_EN
    localparam logic [2:0] S_BUSY_START = S_CLEAR;
`else
    localparam logic [2:0] S_BUSY_START = S_ERR;
`endif

    localparam int unsigned      P          = NCHUNK * NCHUNK;
    localparam logic [ST_W-1:0]  STEP_LAST  = ST_W'(P - 1);
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(NCHUNK - 1);
    localparam logic [SH_W-1:0]  DIAG_SPLIT = SH_W'(NCHUNK - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] a_q, b_q, a_d, b_d, a_adv, b_adv;
    logic [ST_W-1:0]  step_q, step_d;
    logic [SH_W-1:0]  diag_nxt;
    logic             run;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = start ? S_BUSY_START : S_RUN;
            S_RUN: begin
                if (start)
                    state_d = S_BUSY_START;
                else if (step_q == STEP_LAST)
                    state_d = S_DONE;
            end
            S_DONE, S_ERR: if (start) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
    end

    // Walk down the current diagonal (a up, b down); at its end jump to the first cell of the next one.
    always_comb begin
        diag_nxt = SH_W'(a_q) + SH_W'(b_q) + SH_W'(1);
        if (a_q != IDX_MAX && b_q != '0) begin
            a_adv = a_q + IDX_W'(1);
            b_adv = b_q - IDX_W'(1);
        end else if (diag_nxt <= DIAG_SPLIT) begin
            a_adv = '0;
            b_adv = IDX_W'(diag_nxt);
        end else begin
            a_adv = IDX_W'(diag_nxt - DIAG_SPLIT);
            b_adv = IDX_MAX;
        end
    end

    // Step registers only advance while staying in RUN; any other path reloads them with zero.
    always_comb begin
        if (state_q == S_RUN && state_d == S_RUN) begin
            a_d    = a_adv;
            b_d    = b_adv;
            step_d = step_q + ST_W'(1);
        end else begin
            a_d    = '0;
            b_d    = '0;
            step_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= step_d;
        end
    end

    assign run       = (state_q == S_RUN);
    assign a_sel     = run ? a_q : '0;
    assign b_sel     = run ? b_q : '0;
    assign shift_sel = run ? (SH_W'(a_q) + SH_W'(b_q)) : '0;
    assign step_idx  = run ? step_q : '0;
    assign last_pp   = run && (step_q == STEP_LAST);
    assign clk_ena   = run || (state_q == S_CLEAR);
    assign sclr_n    = (state_q != S_CLEAR);
    assign busy      = run || (state_q == S_CLEAR);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign state_out = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: NCHUNK=2 and NCHUNK=4 instances, randomized operations incl. aborts and mid-run resets.
module tb_mult_seq_ctrl;

    localparam int NA = 2;
    localparam int NB = 4;
    localparam int IA = $clog2(NA), SA = $clog2(2*NA-1), TA = $clog2(NA*NA);
    localparam int IB = $clog2(NB), SB = $clog2(2*NB-1), TB = $clog2(NB*NB);

    typedef struct packed {
        int         cyc;
        logic [2:0] state;
        logic [7:0] a, b, sh, st;
        logic       last, ena, sclr, done, busy, err;
    } snap_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic start0 = 1'b0, start1 = 1'b0;
    logic rst0 = 1'b0, rst1 = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IA-1:0] as0, bs0;
    logic [SA-1:0] sh0;
    logic [TA-1:0] st0;
    logic          last0, ena0, sclr0, done0, busy0, err0;
    logic [2:0]    so0;
    logic [IB-1:0] as1, bs1;
    logic [SB-1:0] sh1;
    logic [TB-1:0] st1;
    logic          last1, ena1, sclr1, done1, busy1, err1;
    logic [2:0]    so1;

    mult_seq_ctrl #(.NCHUNK(NA)) u_dut0 (
        .clk(clk), .reset_a_n(rst0), .start(start0),
        .a_sel(as0), .b_sel(bs0), .shift_sel(sh0), .step_idx(st0),
        .last_pp(last0), .clk_ena(ena0), .sclr_n(sclr0), .done(done0),
        .busy(busy0), .err(err0), .state_out(so0)
    );

    mult_seq_ctrl #(.NCHUNK(NB)) u_dut1 (
        .clk(clk), .reset_a_n(rst1), .start(start1),
        .a_sel(as1), .b_sel(bs1), .shift_sel(sh1), .step_idx(st1),
        .last_pp(last1), .clk_ena(ena1), .sclr_n(sclr1), .done(done1),
        .busy(busy1), .err(err1), .state_out(so1)
    );

    snap_t exp_q [2][$];
    int    total = 0;
    int    bad   = 0;
    logic  finished = 1'b0;
    logic  fin_ack  = 1'b0;
    logic [1:0] done_d = '0, err_d = '0;
    snap_t cur, e;

    // ---------------- reference model ----------------
    function automatic void pair_at(input int n, input int idx, output int a, output int b);
        int i = 0;
        a = -1;
        b = -1;
        for (int k = 0; k <= 2*n-2; k++) begin
            int lo = (k - n + 1 > 0) ? k - n + 1 : 0;
            int hi = (k < n - 1) ? k : n - 1;
            for (int x = lo; x <= hi; x++) begin
                if (i == idx) begin
                    a = x;
                    b = k - x;
                end
                i++;
            end
        end
    endfunction

    function automatic snap_t mk(input int c, input int st, input int a, input int b,
                                 input int step, input bit last);
        snap_t s;
        s.cyc   = c;
        s.state = 3'(st);
        s.a     = 8'(a);
        s.b     = 8'(b);
        s.sh    = 8'(a + b);
        s.st    = 8'(step);
        s.last  = last;
        s.ena   = (st == 1 || st == 2);
        s.sclr  = (st != 1);
        s.done  = (st == 3);
        s.busy  = (st == 1 || st == 2);
        s.err   = (st == 4);
        return s;
    endfunction

    function automatic int nchunk_of(input int id);
        return (id == 0) ? NA : NB;
    endfunction

    // CLEAR at c0 followed by the first `count` RUN steps
    function automatic void push_partial(input int id, input int c0, input int count);
        int n = nchunk_of(id);
        int p = n * n;
        int a, b;
        exp_q[id].push_back(mk(c0, 1, 0, 0, 0, 1'b0));
        for (int i = 0; i < count; i++) begin
            pair_at(n, i, a, b);
            exp_q[id].push_back(mk(c0 + 1 + i, 2, a, b, i, i == p - 1));
        end
    endfunction

    function automatic void push_run(input int id, input int c0);
        int n = nchunk_of(id);
        int p = n * n;
        push_partial(id, c0, p);
        exp_q[id].push_back(mk(c0 + p + 1, 3, 0, 0, 0, 1'b0));
    endfunction

    // ---------------- monitor ----------------
    function automatic snap_t sample(input int id);
        snap_t s;
        s.cyc = cyc;
        if (id == 0) begin
            s.state = so0; s.a = 8'(as0); s.b = 8'(bs0); s.sh = 8'(sh0); s.st = 8'(st0);
            s.last = last0; s.ena = ena0; s.sclr = sclr0; s.done = done0; s.busy = busy0; s.err = err0;
        end else begin
            s.state = so1; s.a = 8'(as1); s.b = 8'(bs1); s.sh = 8'(sh1); s.st = 8'(st1);
            s.last = last1; s.ena = ena1; s.sclr = sclr1; s.done = done1; s.busy = busy1; s.err = err1;
        end
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("cyc=%0d state=%0d a=%0d b=%0d sh=%0d step=%0d last=%0d ena=%0d sclr_n=%0d done=%0d busy=%0d err=%0d",
                         s.cyc, s.state, s.a, s.b, s.sh, s.st, s.last, s.ena, s.sclr, s.done, s.busy, s.err);
    endfunction

    function automatic logic rst_of(input int id);
        return (id == 0) ? rst0 : rst1;
    endfunction

    function void compare(input string name, input int id, input snap_t act, input snap_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst=%0d actual: %s | required: %s", name, id, fmt(act), fmt(req));
        end
    endfunction

    always @(negedge clk or negedge rst0 or negedge rst1) begin
        if (clk === 1'b1) begin
            // reset dropped between edges: outputs must settle without a clock
            #1;
            for (int id = 0; id < 2; id++)
                if (!rst_of(id)) compare("async_reset", id, sample(id), mk(cyc, 0, 0, 0, 0, 1'b0));
        end else if ($time > 0) begin
            for (int id = 0; id < 2; id++) begin
                cur = sample(id);
                if (!rst_of(id)) begin
                    compare("reset_state", id, cur, mk(cyc, 0, 0, 0, 0, 1'b0));
                end else if (cur.ena || (cur.done && !done_d[id]) || (cur.err && !err_d[id])) begin
                    if (exp_q[id].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event inst=%0d actual: %s | required: no event", id, fmt(cur));
                    end else begin
                        e = exp_q[id].pop_front();
                        compare("sequence", id, cur, e);
                    end
                end
                done_d[id] = cur.done;
                err_d[id]  = cur.err;
            end
            if (finished && !fin_ack) begin
                for (int id = 0; id < 2; id++) begin
                    total++;
                    if (exp_q[id].size() != 0) begin
                        bad++;
                        $display("FAIL missing_events inst=%0d actual pending=%0d required pending=0",
                                 id, exp_q[id].size());
                    end
                end
                fin_ack = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_start(input int id, input logic v);
        if (id == 0) start0 = v; else start1 = v;
    endtask

    task automatic set_rst(input int id, input logic v);
        if (id == 0) rst0 = v; else rst1 = v;
    endtask

    // kind 0: full run; 1: second start at RUN step s (s=-1 means during CLEAR); 2: reset at RUN step s
    task automatic op(input int id, input int kind, input int s);
        int p = nchunk_of(id) * nchunk_of(id);
        int c0, c1;
        set_start(id, 1'b1);
        @(posedge clk);
        #1;
        c0 = cyc;
        set_start(id, 1'b0);
        if (kind == 0) begin
            push_run(id, c0);
            repeat (p + 1) @(posedge clk);
            #1;
        end else if (kind == 1) begin
            push_partial(id, c0, s + 1);
            repeat (s + 1) @(posedge clk);
            #1;
            set_start(id, 1'b1);
            @(posedge clk);
            #1;
            c1 = cyc;
            set_start(id, 1'b0);
`ifdef MULT_SEQ_ABORT_EN
            push_run(id, c1);
            repeat (p + 1) @(posedge clk);
            #1;
`else
            exp_q[id].push_back(mk(c1, 4, 0, 0, 0, 1'b0));
`endif
        end else begin
            push_partial(id, c0, s);
            repeat (s + 1) @(posedge clk);
            #1;
            set_rst(id, 1'b0);
            repeat (2) @(posedge clk);
            #2;
            set_rst(id, 1'b1);
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int p, kind, s, gap;
        repeat (3) @(posedge clk);
        #2;
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int id = 0; id < 2; id++) begin
            p = nchunk_of(id) * nchunk_of(id);
            op(id, 0, 0);
            op(id, 0, 0);
            op(id, 1, 2);
            op(id, 0, 0);
            op(id, 1, -1);
            op(id, 0, 0);
            op(id, 2, 1);
            op(id, 0, 0);
            for (int r = 0; r < 10; r++) begin
                kind = $urandom_range(0, 2);
                s    = (kind == 1) ? $urandom_range(0, p) - 1 : $urandom_range(0, p - 1);
                gap  = $urandom_range(0, 3);
                repeat (gap) @(posedge clk);
                if (gap != 0) #1;
                op(id, kind, s);
            end
            op(id, 0, 0);
        end
        finished = 1'b1;
        repeat (4) @(posedge clk);
        if (!fin_ack) begin
            $display("FAIL final_drain actual: monitor silent required: drain acknowledged");
            $fatal(1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
